pic_param_core: RTL and testbench

- Parametrised, clocked successor of the 8259A-style interrupt controller core.
- Merges IRR, IMR, ISR, priority resolver and INTA vector control into one synchronous block with a simple register port.
- Sits between NUM_IRQ device request lines and the CPU-side INT/INTA handshake.
- Adds generic channel count, runtime edge/level mode, rotating priority and specific/non-specific EOI.

---
 rtl/pic_param_core.sv | 196 +++++++++++++++++++
 tb/tb_pic_param_core.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_param_core.sv
// pic_param_core: parametrised 8259A-style interrupt controller (IRR/IMR/ISR, resolver, INTA vectoring).
// Define PIC_PARAM_AUTO_EOI_EN to enable the auto-EOI control bit (CTRL bit2).
module pic_param_core #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               wr_en,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rd_data,
  output logic               int_out,
  input  logic               inta,
  output logic               vec_valid,
  output logic [VEC_W-1:0]   vec_out
);
  localparam int unsigned IDX_W  = $clog2(NUM_IRQ);
  localparam int unsigned RANK_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_IMR  = 3'd1;
  localparam logic [2:0] A_EOI  = 3'd2;
  localparam logic [2:0] A_IRR  = 3'd3;
  localparam logic [2:0] A_ISR  = 3'd4;

  logic [1:0]         state, state_nxt;
  logic               level_mode, rotate_en, aeoi;
  logic [VEC_W-1:0]   vec_base;
  logic [NUM_IRQ-1:0] irr, imr, isr, prev_irq;
  logic [IDX_W-1:0]   prio_ptr;

  logic               ctrl_wr, imr_wr, eoi_wr;
  logic [NUM_IRQ-1:0] req;
  logic               cand_found, isr_found, cand_ok;
  logic [IDX_W-1:0]   cand_idx, isr_idx, eoi_idx;
  logic [RANK_W-1:0]  cand_rank, isr_rank;
  int unsigned        pos;
  logic               eoi_do, ack_set;
  logic               int_nxt, vv_nxt;
  logic [VEC_W-1:0]   vec_nxt;
  logic [NUM_IRQ-1:0] ack_onehot, eoi_onehot;
  logic               unused_bits;

  assign ctrl_wr     = wr_en && (addr == A_CTRL);
  assign imr_wr      = wr_en && (addr == A_IMR);
  assign eoi_wr      = wr_en && (addr == A_EOI);
  assign unused_bits = ^wdata;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] k);
    return (32'(k) == NUM_IRQ - 1) ? '0 : k + 1'b1;
  endfunction

  // Rotating resolver: scan from the priority pointer, first set bit wins.
  always_comb begin
    req        = irr & ~imr;
    cand_found = 1'b0;
    isr_found  = 1'b0;
    cand_idx   = '0;
    isr_idx    = '0;
    cand_rank  = '0;
    isr_rank   = '0;
    pos        = 0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      pos = 32'(prio_ptr) + 32'(k);
      if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
      if (!cand_found && req[IDX_W'(pos)]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(pos);
        cand_rank  = RANK_W'(k);
      end
      if (!isr_found && isr[IDX_W'(pos)]) begin
        isr_found = 1'b1;
        isr_idx   = IDX_W'(pos);
        isr_rank  = RANK_W'(k);
      end
    end
    cand_ok = cand_found && (!isr_found || (cand_rank < isr_rank));
  end

  // EOI decode: specific index or highest-priority in-service bit.
  always_comb begin
    eoi_do  = 1'b0;
    eoi_idx = '0;
    if (eoi_wr) begin
      if (wdata[8]) begin
        eoi_do  = 32'(wdata[IDX_W-1:0]) < NUM_IRQ;
        eoi_idx = wdata[IDX_W-1:0];
      end else begin
        eoi_do  = isr_found;
        eoi_idx = isr_idx;
      end
    end
  end

  // Handshake next-state and registered-output values.
  always_comb begin
    state_nxt = state;
    int_nxt   = int_out;
    vv_nxt    = 1'b0;
    vec_nxt   = vec_out;
    ack_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand_ok) begin
          state_nxt = ST_PEND;
          int_nxt   = 1'b1;
        end
      end
      ST_PEND: begin
        if (inta) begin
          state_nxt = ST_ACK;
          int_nxt   = 1'b0;
          vv_nxt    = 1'b1;
          ack_set   = cand_ok;
          vec_nxt   = cand_ok ? vec_base + VEC_W'(cand_idx)
                              : vec_base + VEC_W'(NUM_IRQ - 1);
        end else if (!cand_ok) begin
          state_nxt = ST_IDLE;
          int_nxt   = 1'b0;
        end
      end
      ST_ACK: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        int_nxt   = 1'b0;
      end
    endcase
  end

  assign ack_onehot = ack_set ? (NUM_IRQ'(1) << cand_idx) : '0;
  assign eoi_onehot = eoi_do ? (NUM_IRQ'(1) << eoi_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      int_out    <= 1'b0;
      vec_valid  <= 1'b0;
      vec_out    <= '0;
      level_mode <= 1'b0;
      rotate_en  <= 1'b0;
      vec_base   <= '0;
      imr        <= '1;
      irr        <= '0;
      isr        <= '0;
      prev_irq   <= '0;
      prio_ptr   <= '0;
    end else begin
      state     <= state_nxt;
      int_out   <= int_nxt;
      vec_valid <= vv_nxt;
      vec_out   <= vec_nxt;
      prev_irq  <= irq_in;
      if (ctrl_wr) begin
        level_mode <= wdata[0];
        rotate_en  <= wdata[1];
        vec_base   <= wdata[VEC_W+7:8];
      end
      if (imr_wr) imr <= wdata[NUM_IRQ-1:0];
      // A fresh edge outranks the acknowledge clear of the same bit.
      if (ctrl_wr && level_mode && !wdata[0]) irr <= '0;
      else if (level_mode)                    irr <= irq_in;
      else                                    irr <= (irr & ~ack_onehot) | (irq_in & ~prev_irq);
      isr <= (isr & ~eoi_onehot) | (aeoi ? '0 : ack_onehot);
      if (rotate_en) begin
        if (ack_set && aeoi) prio_ptr <= ptr_after(cand_idx);
        else if (eoi_do)     prio_ptr <= ptr_after(eoi_idx);
      end
    end
  end

`ifdef PIC_PARAM_AUTO_EOI_EN
  always_ff @(posedge clk) begin
    if (reset)        aeoi <= 1'b0;
    else if (ctrl_wr) aeoi <= wdata[2];
  end
`else
  assign aeoi = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      A_CTRL:  rd_data = (32'(vec_base) << 8) | 32'({aeoi, rotate_en, level_mode});
      A_IMR:   rd_data = 32'(imr);
      A_IRR:   rd_data = 32'(irr);
      A_ISR:   rd_data = 32'(isr);
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_pic_param_core.sv
// tb_pic_param_core: directed scenarios plus randomized run against a behavioural interrupt-controller model.
module tb_pic_param_core;
  localparam int N  = 8;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic          wr_en = 1'b0;
  logic [2:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rd_data;
  logic          int_out;
  logic          inta = 1'b0;
  logic          vec_valid;
  logic [VW-1:0] vec_out;

  int n_vec = 0;
  int n_err = 0;

  pic_param_core #(.NUM_IRQ(N), .VEC_W(VW)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rd_data(rd_data), .int_out(int_out), .inta(inta),
    .vec_valid(vec_valid), .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [N-1:0] m_irr, m_isr, m_imr, m_prev;
  logic         m_level, m_rot, m_aeoi, m_int, m_vv;
  logic [7:0]   m_base, m_vec;
  int           m_ptr, m_phase;

  function automatic int rank(input int i);
    return (i - m_ptr + N) % N;
  endfunction

  function automatic int top(input logic [N-1:0] v);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'b0, m_base, 5'b0, m_aeoi, m_rot, m_level};
      3'd1: return 32'(m_imr);
      3'd3: return 32'(m_irr);
      3'd4: return 32'(m_isr);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [N-1:0] n_irr, clr, setb, ackclr;
    int c, s, eidx, n_ptr, n_phase;
    bit c_ok;
    logic n_int, n_vv;
    logic [7:0] n_vec;
    if (reset) begin
      m_irr = '0; m_isr = '0; m_imr = '1; m_prev = '0;
      m_level = 0; m_rot = 0; m_aeoi = 0; m_base = '0;
      m_ptr = 0; m_phase = 0; m_int = 0; m_vv = 0; m_vec = '0;
      return;
    end
    c = top(m_irr & ~m_imr);
    s = top(m_isr);
    c_ok = (c >= 0) && (s < 0 || rank(c) < rank(s));
    clr = '0; setb = '0; ackclr = '0; n_ptr = m_ptr;
    n_phase = m_phase; n_int = m_int; n_vv = 0; n_vec = m_vec;
    if (wr_en && addr == 3'd2) begin
      eidx = wdata[8] ? int'(wdata[2:0]) : s;
      if (eidx >= 0 && eidx < N) begin
        clr[eidx] = 1'b1;
        if (m_rot) n_ptr = (eidx + 1) % N;
      end
    end
    if (m_phase == 0) begin
      if (c_ok) begin n_phase = 1; n_int = 1; end
    end else if (m_phase == 1) begin
      if (inta) begin
        n_phase = 2; n_int = 0; n_vv = 1;
        if (c_ok) begin
          n_vec = 8'(m_base + c);
          ackclr[c] = 1'b1;
          if (!m_aeoi) setb[c] = 1'b1;
          else if (m_rot) n_ptr = (c + 1) % N;
        end else begin
          n_vec = 8'(m_base + N - 1);
        end
      end else if (!c_ok) begin
        n_phase = 0; n_int = 0;
      end
    end else begin
      n_phase = 0;
    end
    if (wr_en && addr == 3'd0 && m_level && !wdata[0]) n_irr = '0;
    else if (m_level) n_irr = irq_in;
    else n_irr = (m_irr & ~ackclr) | (irq_in & ~m_prev);
    m_isr = (m_isr & ~clr) | setb;
    m_irr = n_irr;
    m_ptr = n_ptr; m_phase = n_phase; m_int = n_int; m_vv = n_vv; m_vec = n_vec;
    m_prev = irq_in;
    if (wr_en && addr == 3'd0) begin
      m_level = wdata[0]; m_rot = wdata[1]; m_base = wdata[15:8];
`ifdef PIC_PARAM_AUTO_EOI_EN
      m_aeoi = wdata[2];
`endif
    end
    if (wr_en && addr == 3'd1) m_imr = wdata[N-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = '0; addr = '0;
  endtask

  task automatic do_reset();
    irq_in = '0; inta = 1'b0; wr_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic setup(input logic [31:0] ctrl);
    do_reset();
    write_reg(3'd1, 32'h0);
    write_reg(3'd0, ctrl);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL reset_int_out: got %b expected 0", int_out); end
    n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL reset_vec_valid: got %b expected 0", vec_valid); end
    n_vec++; if (vec_out !== 8'h00) begin n_err++; $display("FAIL reset_vec_out: got %h expected 00", vec_out); end
    addr = 3'd1; #1;
    n_vec++; if (rd_data !== 32'hFF) begin n_err++; $display("FAIL reset_imr: got %h expected 000000ff", rd_data); end
    addr = 3'd0; #1;
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", rd_data); end
    write_reg(3'd2, 32'h0);
    write_reg(3'd3, 32'hFF);
    write_reg(3'd5, 32'hFFFF_FFFF);
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL eoi_on_empty_isr: got %h expected 0", rd_data); end
    addr = 3'd3; #1;
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL irr_read_only: got %h expected 0", rd_data); end
    addr = 3'd5; #1;
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h expected 0", rd_data); end
    addr = 3'd0;
  endtask

  task automatic test_edge_basic();
    setup(32'h2000);
    irq_in = 8'h08; tick();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL edge_latency_1: got %b expected 0", int_out); end
    tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL edge_latency_2: got %b expected 1", int_out); end
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_valid !== 1'b1 || vec_out !== 8'h23) begin n_err++; $display("FAIL ack_vec3: got %b/%h expected 1/23", vec_valid, vec_out); end
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL ack_int_drop: got %b expected 0", int_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL ack_isr: got %h expected 08", rd_data); end
    addr = 3'd3; #1;
    n_vec++; if (rd_data !== 32'h00) begin n_err++; $display("FAIL ack_irr: got %h expected 00", rd_data); end
    tick();
    n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL vec_valid_pulse: got %b expected 0", vec_valid); end
  endtask

  task automatic test_nesting();
    setup(32'h2000);
    irq_in = 8'h08; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0; tick();
    irq_in = 8'h28; tick(); tick(); tick();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL nest_lower_blocked: got %b expected 0", int_out); end
    irq_in = 8'h2A; tick(); tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL nest_higher_int: got %b expected 1", int_out); end
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_out !== 8'h21) begin n_err++; $display("FAIL nest_vec1: got %h expected 21", vec_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h0A) begin n_err++; $display("FAIL nest_isr: got %h expected 0a", rd_data); end
    tick();
    write_reg(3'd2, 32'h0);
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL nonspec_eoi: got %h expected 08", rd_data); end
  endtask

  task automatic test_rotate();
    setup(32'h2002);
    irq_in = 8'h04; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_out !== 8'h22) begin n_err++; $display("FAIL rot_vec2: got %h expected 22", vec_out); end
    tick();
    write_reg(3'd2, 32'h102);
    irq_in = 8'h0E; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_out !== 8'h23) begin n_err++; $display("FAIL rot_ptr3_vec: got %h expected 23", vec_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL rot_isr: got %h expected 08", rd_data); end
    tick();
    write_reg(3'd2, 32'h0);
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_out !== 8'h21) begin n_err++; $display("FAIL rot_wrap_vec1: got %h expected 21", vec_out); end
  endtask

  task automatic test_level_spurious();
    setup(32'h2001);
    irq_in = 8'h40; tick(); tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL level_int: got %b expected 1", int_out); end
    irq_in = 8'h00; tick(); tick();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL level_drop: got %b expected 0", int_out); end
    irq_in = 8'h40; tick(); tick();
    irq_in = 8'h00; tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL level_int_still_high: got %b expected 1", int_out); end
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_valid !== 1'b1 || vec_out !== 8'h27) begin n_err++; $display("FAIL spurious_vec: got %b/%h expected 1/27", vec_valid, vec_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL spurious_isr: got %h expected 0", rd_data); end
  endtask

  task automatic test_mask();
    setup(32'h2000);
    irq_in = 8'h10; tick(); tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL mask_pre_int: got %b expected 1", int_out); end
    write_reg(3'd1, 32'h10); tick();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL mask_deassert: got %b expected 0", int_out); end
    write_reg(3'd1, 32'h00); tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL unmask_reassert: got %b expected 1", int_out); end
  endtask

  task automatic test_back_to_back();
    setup(32'h2000);
    irq_in = 8'h04; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0; tick();
    irq_in = 8'h06; tick(); tick();
    wr_en = 1'b1; addr = 3'd2; wdata = 32'h101; inta = 1'b1;
    tick();
    wr_en = 1'b0; wdata = '0; inta = 1'b0;
    n_vec++; if (vec_out !== 8'h21) begin n_err++; $display("FAIL eoi_inta_vec: got %h expected 21", vec_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== 32'h06) begin n_err++; $display("FAIL eoi_inta_isr: got %h expected 06", rd_data); end
    setup(32'h2000);
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h08; inta = 1'b1; tick(); inta = 1'b0;
    addr = 3'd3; #1;
    n_vec++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL edge_beats_clear: got %h expected 08", rd_data); end
    tick();
    n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL same_idx_blocked: got %b expected 0", int_out); end
    write_reg(3'd2, 32'h0); tick();
    n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL reassert_after_eoi: got %b expected 1", int_out); end
  endtask

  task automatic test_aeoi_reset_mid_ack();
    logic [31:0] exp_ctrl, exp_isr;
`ifdef PIC_PARAM_AUTO_EOI_EN
    exp_ctrl = 32'h2004; exp_isr = 32'h00;
`else
    exp_ctrl = 32'h2000; exp_isr = 32'h01;
`endif
    setup(32'h2004);
    addr = 3'd0; #1;
    n_vec++; if (rd_data !== exp_ctrl) begin n_err++; $display("FAIL ctrl_aeoi_bit: got %h expected %h", rd_data, exp_ctrl); end
    irq_in = 8'h01; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0;
    n_vec++; if (vec_valid !== 1'b1 || vec_out !== 8'h20) begin n_err++; $display("FAIL aeoi_vec: got %b/%h expected 1/20", vec_valid, vec_out); end
    addr = 3'd4; #1;
    n_vec++; if (rd_data !== exp_isr) begin n_err++; $display("FAIL aeoi_isr: got %h expected %h", rd_data, exp_isr); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++; if (vec_valid !== 1'b0 || int_out !== 1'b0 || vec_out !== 8'h00) begin n_err++; $display("FAIL reset_mid_ack: got %b/%b/%h expected 0/0/00", vec_valid, int_out, vec_out); end
    addr = 3'd1; #1;
    n_vec++; if (rd_data !== 32'hFF) begin n_err++; $display("FAIL reset_mid_ack_imr: got %h expected ff", rd_data); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'(1) << $urandom_range(0, 7));
      inta  = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      addr  = 3'($urandom_range(0, 7));
      case (addr)
        3'd0: wdata = {16'b0, 8'($urandom), 5'b0, 3'($urandom)};
        3'd1: wdata = 32'($urandom & $urandom & 32'hFF);
        3'd2: wdata = {23'b0, 1'($urandom), 5'b0, 3'($urandom)};
        default: wdata = $urandom;
      endcase
      #1;
      exp = model_read(addr);
      n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL rnd_rd cyc %0d addr %0d: got %h expected %h", cyc, addr, rd_data, exp); end
      tick();
      n_vec++; if (int_out !== m_int) begin n_err++; $display("FAIL rnd_int cyc %0d: got %b expected %b", cyc, int_out, m_int); end
      n_vec++; if (vec_valid !== m_vv) begin n_err++; $display("FAIL rnd_vv cyc %0d: got %b expected %b", cyc, vec_valid, m_vv); end
      n_vec++; if (vec_out !== m_vec) begin n_err++; $display("FAIL rnd_vec cyc %0d: got %h expected %h", cyc, vec_out, m_vec); end
    end
    reset = 1'b0; wr_en = 1'b0; inta = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_nesting();
    test_rotate();
    test_level_spurious();
    test_mask();
    test_back_to_back();
    test_aeoi_reset_mid_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
